// File: rtl/memory_responder.sv
// Multi-channel memory responder: per-channel read/write FSMs with fixed latency
// over a shared word array, plus a backdoor preload port.
module memory_responder #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2,
    parameter int unsigned WRITE_ENABLE  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data    [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    input  logic                    load_en,
    input  logic [ADDR_BITS-1:0]    load_addr,
    input  logic [DATA_BITS-1:0]    load_data
);

    localparam int unsigned DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0]  RD_INIT = 4'(READ_LATENCY - 1);
    localparam logic [3:0]  WR_INIT = 4'(WRITE_LATENCY - 1);
    localparam logic        WR_EN   = (WRITE_ENABLE != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_RELEASE
    } state_e;

    logic [DATA_BITS-1:0]    mem_q [DEPTH];
    logic [DATA_BITS-1:0]    mem_d [DEPTH];

    state_e                  rd_state_q [NUM_CHANNELS];
    state_e                  rd_state_d [NUM_CHANNELS];
    logic [3:0]              rd_cnt_q   [NUM_CHANNELS];
    logic [3:0]              rd_cnt_d   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    rd_addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    rd_addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    rd_data_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    rd_data_d  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rd_ready_q;
    logic [NUM_CHANNELS-1:0] rd_ready_d;

    state_e                  wr_state_q [NUM_CHANNELS];
    state_e                  wr_state_d [NUM_CHANNELS];
    logic [3:0]              wr_cnt_q   [NUM_CHANNELS];
    logic [3:0]              wr_cnt_d   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    wr_addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    wr_addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wr_data_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wr_data_d  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] wr_ready_q;
    logic [NUM_CHANNELS-1:0] wr_ready_d;

    logic [NUM_CHANNELS-1:0] wr_valid;
    logic [NUM_CHANNELS-1:0] wr_commit;
    logic [ADDR_BITS-1:0]    wr_commit_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wr_commit_data [NUM_CHANNELS];

    assign wr_valid = mem_write_valid & {NUM_CHANNELS{WR_EN}};

    // Read FSMs: data is sampled from the array on the edge that enters RESP.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            rd_state_d[ch] = rd_state_q[ch];
            rd_cnt_d[ch]   = rd_cnt_q[ch];
            rd_addr_d[ch]  = rd_addr_q[ch];
            rd_data_d[ch]  = rd_data_q[ch];
            rd_ready_d[ch] = 1'b0;
            case (rd_state_q[ch])
                ST_IDLE: begin
                    if (mem_read_valid[ch]) begin
                        rd_addr_d[ch] = mem_read_address[ch];
                        rd_cnt_d[ch]  = RD_INIT;
                        if (READ_LATENCY == 1) begin
                            rd_state_d[ch] = ST_RESP;
                            rd_ready_d[ch] = 1'b1;
                            rd_data_d[ch]  = mem_q[mem_read_address[ch]];
                        end else begin
                            rd_state_d[ch] = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (rd_cnt_q[ch] == 4'd0) begin
                        rd_state_d[ch] = ST_RESP;
                        rd_ready_d[ch] = 1'b1;
                        rd_data_d[ch]  = mem_q[rd_addr_q[ch]];
                    end else begin
                        rd_cnt_d[ch] = rd_cnt_q[ch] - 4'd1;
                    end
                end
                ST_RESP: begin
                    rd_state_d[ch] = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!mem_read_valid[ch]) begin
                        rd_state_d[ch] = ST_IDLE;
                    end
                end
                default: begin
                    rd_state_d[ch] = ST_IDLE;
                end
            endcase
        end
    end

    // Write FSMs: the commit request fires on the edge that enters RESP.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            wr_state_d[ch]     = wr_state_q[ch];
            wr_cnt_d[ch]       = wr_cnt_q[ch];
            wr_addr_d[ch]      = wr_addr_q[ch];
            wr_data_d[ch]      = wr_data_q[ch];
            wr_ready_d[ch]     = 1'b0;
            wr_commit[ch]      = 1'b0;
            wr_commit_addr[ch] = wr_addr_q[ch];
            wr_commit_data[ch] = wr_data_q[ch];
            case (wr_state_q[ch])
                ST_IDLE: begin
                    if (wr_valid[ch]) begin
                        wr_addr_d[ch] = mem_write_address[ch];
                        wr_data_d[ch] = mem_write_data[ch];
                        wr_cnt_d[ch]  = WR_INIT;
                        if (WRITE_LATENCY == 1) begin
                            wr_state_d[ch]     = ST_RESP;
                            wr_ready_d[ch]     = 1'b1;
                            wr_commit[ch]      = 1'b1;
                            wr_commit_addr[ch] = mem_write_address[ch];
                            wr_commit_data[ch] = mem_write_data[ch];
                        end else begin
                            wr_state_d[ch] = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (wr_cnt_q[ch] == 4'd0) begin
                        wr_state_d[ch] = ST_RESP;
                        wr_ready_d[ch] = 1'b1;
                        wr_commit[ch]  = 1'b1;
                    end else begin
                        wr_cnt_d[ch] = wr_cnt_q[ch] - 4'd1;
                    end
                end
                ST_RESP: begin
                    wr_state_d[ch] = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!wr_valid[ch]) begin
                        wr_state_d[ch] = ST_IDLE;
                    end
                end
                default: begin
                    wr_state_d[ch] = ST_IDLE;
                end
            endcase
        end
    end

    // Later assignments win: ascending channel order, then the preload port last.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (wr_commit[ch]) begin
                mem_d[wr_commit_addr[ch]] = wr_commit_data[ch];
            end
        end
        if (load_en) begin
            mem_d[load_addr] = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                rd_state_q[ch] <= ST_IDLE;
                rd_cnt_q[ch]   <= '0;
                rd_addr_q[ch]  <= '0;
                rd_data_q[ch]  <= '0;
                wr_state_q[ch] <= ST_IDLE;
                wr_cnt_q[ch]   <= '0;
                wr_addr_q[ch]  <= '0;
                wr_data_q[ch]  <= '0;
            end
            rd_ready_q <= '0;
            wr_ready_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_ready_q <= rd_ready_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign mem_read_ready  = rd_ready_q;
    assign mem_read_data   = rd_data_q;
    assign mem_write_ready = wr_ready_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a writable instance and a read-only
// instance share all stimulus; a negedge monitor pops expected responses.
module tb_memory_responder;

    typedef struct {
        int unsigned edge_n;
        logic [7:0]  data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] rd_valid;
    logic [7:0] rd_addr [4];
    logic [3:0] wr_valid;
    logic [7:0] wr_addr [4];
    logic [7:0] wr_data [4];
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;

    logic [3:0] rd_ready;
    logic [7:0] rd_data [4];
    logic [3:0] wr_ready;
    logic [3:0] ro_rd_ready;
    logic [7:0] ro_rd_data [4];
    logic [3:0] ro_wr_ready;

    int unsigned edge_cnt;
    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned ro_wr_pulses;

    exp_t        rd_exp    [4][$];
    exp_t        ro_exp    [4][$];
    int unsigned wr_exp    [4][$];

    memory_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4),
        .READ_LATENCY(2), .WRITE_LATENCY(2), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rd_valid), .mem_read_address(rd_addr),
        .mem_read_ready(rd_ready), .mem_read_data(rd_data),
        .mem_write_valid(wr_valid), .mem_write_address(wr_addr),
        .mem_write_data(wr_data), .mem_write_ready(wr_ready),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    memory_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4),
        .READ_LATENCY(2), .WRITE_LATENCY(2), .WRITE_ENABLE(0)
    ) dut_ro (
        .clk(clk), .reset(reset),
        .mem_read_valid(rd_valid), .mem_read_address(rd_addr),
        .mem_read_ready(ro_rd_ready), .mem_read_data(ro_rd_data),
        .mem_write_valid(wr_valid), .mem_write_address(wr_addr),
        .mem_write_data(wr_data), .mem_write_ready(ro_wr_ready),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: every ready pulse must match the head of its channel queue.
    initial begin
        exp_t        e;
        int unsigned we;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                if (rd_ready[ch]) begin
                    n_tests++;
                    if (rd_exp[ch].size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_unexpected ch%0d: pulse at edge %0d data %h, required no pulse", ch, edge_cnt, rd_data[ch]);
                    end else begin
                        e = rd_exp[ch].pop_front();
                        if (edge_cnt != e.edge_n || rd_data[ch] !== e.data) begin
                            n_fail++;
                            $display("FAIL rd ch%0d: got %h at edge %0d, required %h at edge %0d", ch, rd_data[ch], edge_cnt, e.data, e.edge_n);
                        end
                    end
                end
                if (ro_rd_ready[ch]) begin
                    n_tests++;
                    if (ro_exp[ch].size() == 0) begin
                        n_fail++;
                        $display("FAIL ro_rd_unexpected ch%0d: pulse at edge %0d, required no pulse", ch, edge_cnt);
                    end else begin
                        e = ro_exp[ch].pop_front();
                        if (edge_cnt != e.edge_n || ro_rd_data[ch] !== e.data) begin
                            n_fail++;
                            $display("FAIL ro_rd ch%0d: got %h at edge %0d, required %h at edge %0d", ch, ro_rd_data[ch], edge_cnt, e.data, e.edge_n);
                        end
                    end
                end
                if (wr_ready[ch]) begin
                    n_tests++;
                    if (wr_exp[ch].size() == 0) begin
                        n_fail++;
                        $display("FAIL wr_unexpected ch%0d: pulse at edge %0d, required no pulse", ch, edge_cnt);
                    end else begin
                        we = wr_exp[ch].pop_front();
                        if (edge_cnt != we) begin
                            n_fail++;
                            $display("FAIL wr ch%0d: pulse at edge %0d, required edge %0d", ch, edge_cnt, we);
                        end
                    end
                end
            end
            if (ro_wr_ready != 4'b0) ro_wr_pulses++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue_rd(input int ch, input logic [7:0] a,
                            input logic [7:0] exp_main, input logic [7:0] exp_ro);
        rd_valid[ch] = 1'b1;
        rd_addr[ch]  = a;
        rd_exp[ch].push_back('{edge_n: edge_cnt + 3, data: exp_main});
        ro_exp[ch].push_back('{edge_n: edge_cnt + 3, data: exp_ro});
    endtask

    task automatic issue_wr(input int ch, input logic [7:0] a, input logic [7:0] d);
        wr_valid[ch] = 1'b1;
        wr_addr[ch]  = a;
        wr_data[ch]  = d;
        wr_exp[ch].push_back(edge_cnt + 3);
    endtask

    task automatic check_zero(input string tag);
        n_tests++;
        if ({rd_ready, wr_ready, ro_rd_ready, ro_wr_ready} !== 16'h0) begin
            n_fail++;
            $display("FAIL %s_ready: got %h, required 0000", tag, {rd_ready, wr_ready, ro_rd_ready, ro_wr_ready});
        end
        for (int ch = 0; ch < 4; ch++) begin
            n_tests++;
            if (rd_data[ch] !== 8'h00 || ro_rd_data[ch] !== 8'h00) begin
                n_fail++;
                $display("FAIL %s_data ch%0d: got %h/%h, required 00/00", tag, ch, rd_data[ch], ro_rd_data[ch]);
            end
        end
    endtask

    initial begin
        edge_cnt = 0; n_tests = 0; n_fail = 0; ro_wr_pulses = 0;
        reset = 1'b0; rd_valid = '0; wr_valid = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        for (int ch = 0; ch < 4; ch++) begin
            rd_addr[ch] = '0; wr_addr[ch] = '0; wr_data[ch] = '0;
        end
        step(3);
        check_zero("reset");
        reset = 1'b1;
        step(2);

        // Preload 0x10 and the top address, then read both back.
        load_en = 1'b1; load_addr = 8'h10; load_data = 8'hA5;
        step(1);
        load_addr = 8'hFF; load_data = 8'h5A;
        step(1);
        load_en = 1'b0;
        issue_rd(0, 8'h10, 8'hA5, 8'hA5);
        issue_rd(3, 8'hFF, 8'h5A, 8'h5A);
        step(1); rd_valid = '0; step(5);

        // Write then read on a different channel; read-only copy stays 0.
        issue_wr(1, 8'h20, 8'h3C);
        step(1); wr_valid = '0; step(5);
        issue_rd(2, 8'h20, 8'h3C, 8'h00);
        step(1); rd_valid = '0; step(5);

        // Same-edge collision: ch3 wins, concurrent read sees old value.
        issue_wr(0, 8'h05, 8'h11);
        issue_wr(3, 8'h05, 8'h22);
        issue_rd(2, 8'h05, 8'h00, 8'h00);
        step(1); wr_valid = '0; rd_valid = '0; step(5);
        issue_rd(1, 8'h05, 8'h22, 8'h00);
        step(1); rd_valid = '0; step(5);

        // Preload on the commit edge beats a channel write.
        issue_wr(2, 8'h30, 8'h55);
        step(1); wr_valid = '0;
        step(1); load_en = 1'b1; load_addr = 8'h30; load_data = 8'h99;
        step(1); load_en = 1'b0;
        step(4);
        issue_rd(0, 8'h30, 8'h99, 8'h99);
        step(1); rd_valid = '0; step(5);

        // Held valid for 10 cycles with an address change after accept.
        issue_rd(0, 8'h10, 8'hA5, 8'hA5);
        step(1); rd_addr[0] = 8'h20;
        step(9); rd_valid = '0; step(4);

        // Write address/data changed while busy are ignored.
        issue_wr(3, 8'h50, 8'h66);
        step(1); wr_addr[3] = 8'h51; wr_data[3] = 8'hFF;
        step(1); wr_valid = '0; step(5);
        issue_rd(1, 8'h50, 8'h66, 8'h00);
        issue_rd(2, 8'h51, 8'h00, 8'h00);
        step(1); rd_valid = '0; step(5);

        // Reset one cycle after a ch1 write is accepted: no commit, no pulse.
        wr_valid[1] = 1'b1; wr_addr[1] = 8'h40; wr_data[1] = 8'h77;
        step(2);
        reset = 1'b0; wr_valid = '0;
        #1;
        check_zero("midreset");
        rd_valid[0] = 1'b1; rd_addr[0] = 8'h40;
        step(2);
        check_zero("inreset");
        reset = 1'b1;
        rd_exp[0].push_back('{edge_n: edge_cnt + 3, data: 8'h00});
        ro_exp[0].push_back('{edge_n: edge_cnt + 3, data: 8'h00});
        step(1); rd_valid = '0; step(5);
        issue_rd(3, 8'h10, 8'h00, 8'h00);
        step(1); rd_valid = '0;

        step(20);
        for (int ch = 0; ch < 4; ch++) begin
            n_tests++;
            if (rd_exp[ch].size() != 0 || ro_exp[ch].size() != 0 || wr_exp[ch].size() != 0) begin
                n_fail++;
                $display("FAIL pending ch%0d: rd %0d ro %0d wr %0d responses missing, required 0", ch, rd_exp[ch].size(), ro_exp[ch].size(), wr_exp[ch].size());
            end
        end
        n_tests++;
        if (ro_wr_pulses != 0) begin
            n_fail++;
            $display("FAIL ro_write_ready: got %0d pulses, required 0", ro_wr_pulses);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
